wb_result_unit: RTL and testbench

Write-back result unit for the RISC-V core: the consumer end of the execute datapath that the ALU operand muxes feed. It accepts one retired instruction per handshake and selects the register-file write value from the ALU result, load data, PC+4 or immediate. Loads hold it in a wait state until data memory returns read data, with optional byte/half load extension. It then drives a registered one-cycle write strobe into the register file.

---
 rtl/wb_result_unit_if.sv | 33 +++
 rtl/wb_result_unit.sv | 126 ++++++++++++
 tb/tb_wb_result_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_result_unit_if.sv
// Handshake and register-file write bus between the execute stage, data memory
// and the write-back result unit. The slave modport is the unit's side.
interface wb_result_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] immout;
  logic [XLEN-1:0] pc_plus4;
  logic [1:0]      MemtoReg;
  logic            RegWrite;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy;

  modport master (
    output in_valid, ALUResult, immout, pc_plus4, MemtoReg, RegWrite, rd, funct3,
           mem_rvalid, mem_rdata,
    input  in_ready, wb_we, wb_rd, wb_data, busy
  );

  modport slave (
    input  in_valid, ALUResult, immout, pc_plus4, MemtoReg, RegWrite, rd, funct3,
           mem_rvalid, mem_rdata,
    output in_ready, wb_we, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/wb_result_unit.sv
// Write-back result unit: selects the register-file write value and issues a
// registered one-cycle write strobe. Define WB_LOAD_EXT_EN for byte/half load extension.
module wb_result_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_result_unit_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic            we_q, we_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] sel_result;
  logic [XLEN-1:0] load_value;

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == WAIT_MEM);
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

  always_comb begin
    unique case (bus.MemtoReg)
      2'b10:   sel_result = bus.pc_plus4;
      2'b11:   sel_result = bus.immout;
      default: sel_result = bus.ALUResult;
    endcase
  end

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = bus.mem_rdata[8*off_q +: 8];
    load_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    // Undefined load encodings fall through to the full word, like LW.
    unique case (funct3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'd0, load_byte};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = bus.mem_rdata;
    endcase
  end
`else
  assign load_value = bus.mem_rdata;
  // Load type and offset are kept for the extension build only.
  logic unused_load_info;
  assign unused_load_info = ^{funct3_q, off_q};
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    we_d      = we_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rd_d     = bus.rd;
          funct3_d = bus.funct3;
          off_d    = bus.ALUResult[1:0];
          we_d     = bus.RegWrite && (bus.rd != 5'd0);
          if (bus.MemtoReg == 2'b01) begin
            state_d = WAIT_MEM;
          end else begin
            wb_we_d   = bus.RegWrite && (bus.rd != 5'd0);
            wb_rd_d   = bus.rd;
            wb_data_d = sel_result;
            state_d   = WRITE;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          wb_we_d   = we_q;
          wb_rd_d   = rd_q;
          wb_data_d = load_value;
          state_d   = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      we_q      <= we_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_wb_result_unit.sv
// Directed bench for wb_result_unit; expected load data follows WB_LOAD_EXT_EN.
module tb_wb_result_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  wb_result_unit_if #(.XLEN(32)) bus ();

  wb_result_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid   = 1'b0;
    bus.ALUResult  = '0;
    bus.immout     = '0;
    bus.pc_plus4   = '0;
    bus.MemtoReg   = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.rd         = '0;
    bus.funct3     = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Present one instruction for exactly one accepting edge.
  task automatic issue(input logic [1:0] m2r, input logic rw, input logic [4:0] rd_n,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] imm, input logic [31:0] pc4);
    bus.in_valid  = 1'b1;
    bus.MemtoReg  = m2r;
    bus.RegWrite  = rw;
    bus.rd        = rd_n;
    bus.funct3    = f3;
    bus.ALUResult = alu;
    bus.immout    = imm;
    bus.pc_plus4  = pc4;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  // Load with a given number of wait cycles; checks busy and the final write.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [4:0] rd_n, input int waits,
                         input logic [31:0] rdata, input logic [31:0] exp);
    int busy_cycles;
    busy_cycles = 0;
    issue(2'b01, 1'b1, rd_n, f3, alu, 32'h0, 32'h0);
    for (int i = 0; i < waits; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.wb_we !== 1'b0) check({tag, "_we_early"}, {31'd0, bus.wb_we}, 32'd0);
      if (i < waits - 1) tick();
    end
    check({tag, "_busy_cycles"}, busy_cycles, waits);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    check({tag, "_we"},   {31'd0, bus.wb_we}, 32'd1);
    check({tag, "_rd"},   {27'd0, bus.wb_rd}, {27'd0, rd_n});
    check({tag, "_data"}, bus.wb_data, exp);
    check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    tick();
    check({tag, "_we_off"}, {31'd0, bus.wb_we}, 32'd0);
    check({tag, "_data_hold"}, bus.wb_data, exp);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_we",    {31'd0, bus.wb_we},    32'd0);
    check("rst_rd",    {27'd0, bus.wb_rd},    32'd0);
    check("rst_data",  bus.wb_data,           32'd0);
    check("rst_busy",  {31'd0, bus.busy},     32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU result: write in N+1 only, ready again in N+2.
    issue(2'b00, 1'b1, 5'd5, 3'b010, 32'h0000_1234, 32'h0, 32'h0);
    check("alu_we",    {31'd0, bus.wb_we},    32'd1);
    check("alu_rd",    {27'd0, bus.wb_rd},    32'd5);
    check("alu_data",  bus.wb_data,           32'h0000_1234);
    check("alu_ready_n1", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("alu_we_n2",    {31'd0, bus.wb_we},    32'd0);
    check("alu_ready_n2", {31'd0, bus.in_ready}, 32'd1);
    check("alu_data_hold", bus.wb_data,          32'h0000_1234);

    // PC+4 to x0: no strobe, back to IDLE after two cycles.
    issue(2'b10, 1'b1, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0000_0040);
    check("x0_we_n1",    {31'd0, bus.wb_we},    32'd0);
    check("x0_ready_n1", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("x0_we_n2",    {31'd0, bus.wb_we},    32'd0);
    check("x0_ready_n2", {31'd0, bus.in_ready}, 32'd1);

    // PC+4 link value to a real register.
    issue(2'b10, 1'b1, 5'd1, 3'b000, 32'h0, 32'h0, 32'h0000_0040);
    check("jal_we",   {31'd0, bus.wb_we}, 32'd1);
    check("jal_data", bus.wb_data,        32'h0000_0040);
    tick();

`ifdef WB_LOAD_EXT_EN
    do_load("lb",   3'b000, 32'h0000_0103, 5'd9,  3, 32'h80FF_7F01, 32'hFFFF_FF80);
    do_load("lhu",  3'b101, 32'h0000_0202, 5'd10, 1, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh",   3'b001, 32'h0000_0001, 5'd11, 2, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lbu",  3'b100, 32'h0000_0002, 5'd12, 1, 32'h0085_0000, 32'h0000_0085);
    do_load("f011", 3'b011, 32'h0000_0001, 5'd13, 1, 32'h1234_5678, 32'h1234_5678);
`else
    do_load("lb",   3'b000, 32'h0000_0103, 5'd9,  3, 32'h80FF_7F01, 32'h80FF_7F01);
    do_load("lhu",  3'b101, 32'h0000_0202, 5'd10, 1, 32'hBEEF_0000, 32'hBEEF_0000);
    do_load("f011", 3'b011, 32'h0000_0001, 5'd13, 1, 32'h1234_5678, 32'h1234_5678);
`endif

    // Spurious read-valid pulse in IDLE must be ignored.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    tick();
    bus.mem_rvalid = 1'b0;
    check("spur_we",    {31'd0, bus.wb_we},    32'd0);
    check("spur_busy",  {31'd0, bus.busy},     32'd0);
    check("spur_ready", {31'd0, bus.in_ready}, 32'd1);
    pulses = 0;
    issue(2'b11, 1'b1, 5'd7, 3'b000, 32'h0000_0999, 32'hFFFF_F000, 32'h0);
    check("imm_rd",   {27'd0, bus.wb_rd}, 32'd7);
    check("imm_data", bus.wb_data,        32'hFFFF_F000);
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_we === 1'b1) pulses++;
      tick();
    end
    check("imm_pulses", pulses, 32'd1);

    // Reset while waiting for memory discards the pending write.
    issue(2'b01, 1'b1, 5'd20, 3'b010, 32'h0000_0300, 32'h0, 32'h0);
    check("rstw_busy_pre", {31'd0, bus.busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstw_busy",  {31'd0, bus.busy},     32'd0);
    check("rstw_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rstw_data",  bus.wb_data,           32'd0);
    check("rstw_rd",    {27'd0, bus.wb_rd},    32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mem_rvalid = 1'b0;
      if (bus.wb_we === 1'b1) pulses++;
    end
    check("rstw_pulses", pulses, 32'd0);
    check("rstw_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("rstw_data_after",  bus.wb_data,           32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
